// File: rtl/ram16k_arbiter_pkg.sv
// ram_arb_pkg: shared widths and types for ram16k_arbiter.
// Optional statistics counters are enabled with RAM16K_ARB_STATS_EN.
package ram_arb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  typedef enum logic {PORT_A, PORT_B} port_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;
endpackage

// File: rtl/ram16k_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on conflict the port not served last wins.
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic gnt_a,
  output logic gnt_b
);
  assign gnt_a = req_a & (~req_b | last_b);
  assign gnt_b = req_b & (~req_a | ~last_b);
endmodule

// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter: shares one RAM16K between ports A and B, one access per cycle, round-robin.
// Define RAM16K_ARB_STATS_EN to add saturating grant/conflict counters.
module ram16k_arbiter import ram_arb_pkg::*; #(
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int ADDR_W = ram_arb_pkg::ADDR_W
`ifdef RAM16K_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
`ifdef RAM16K_ARB_STATS_EN
  , output logic [CNT_W-1:0] a_gnt_cnt,
  output logic [CNT_W-1:0]   b_gnt_cnt,
  output logic [CNT_W-1:0]   conflict_cnt
`endif
);
  logic              last_b_q, a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  port_e             sel;
  // Requests are masked during reset so nothing is granted or written.
  rr_arb2 u_arb (
    .req_a (a_req & ~reset),
    .req_b (b_req & ~reset),
    .last_b(last_b_q),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );
  always_comb begin
    sel         = b_gnt ? PORT_B : PORT_A;
    ram_address = (sel == PORT_B) ? b_addr : a_addr;
    ram_in      = (sel == PORT_B) ? b_wdata : a_wdata;
    ram_load    = (a_gnt & a_we) | (b_gnt & b_we);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      if (a_gnt | b_gnt) last_b_q <= b_gnt;
      a_rvalid_q <= a_gnt & ~a_we;
      b_rvalid_q <= b_gnt & ~b_we;
      if (a_gnt & ~a_we) a_rdata_q <= ram_out;
      if (b_gnt & ~b_we) b_rdata_q <= ram_out;
    end
  end
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
`ifdef RAM16K_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, c_cnt_q, c_cnt_d;
  always_comb begin
    a_cnt_d = a_cnt_q + CNT_W'(a_gnt && a_cnt_q != CNT_MAX);
    b_cnt_d = b_cnt_q + CNT_W'(b_gnt && b_cnt_q != CNT_MAX);
    c_cnt_d = c_cnt_q + CNT_W'(a_req && b_req && !reset && c_cnt_q != CNT_MAX);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end
  assign a_gnt_cnt    = a_cnt_q;
  assign b_gnt_cnt    = b_cnt_q;
  assign conflict_cnt = c_cnt_q;
`endif
endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb_ram16k_arbiter: randomized bench with a RAM16K model behind the arbiter and a reference model.
module tb_ram16k_arbiter;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int CW = 16;
  logic clk = 0, reset = 1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, ram_address;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, ram_in, ram_out;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_load;
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] mdl [2**AW];
  int n_tests = 0, n_fail = 0;
  int m_last_b;
  logic m_av, m_bv;
  logic [DW-1:0] m_ad, m_bd;
  longint m_acnt, m_bcnt, m_ccnt;
  logic ga, gb, prev_b, pa, pb, paw, pbw;
  logic [AW-1:0] paa, pba;
  logic [DW-1:0] pad, pbd;
`ifdef RAM16K_ARB_STATS_EN
  logic [CW-1:0] a_gnt_cnt, b_gnt_cnt, conflict_cnt;
`endif

  ram16k_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
`ifdef RAM16K_ARB_STATS_EN
    , .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign ram_out = ram[ram_address];
  always @(posedge clk) if (ram_load) ram[ram_address] <= ram_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_last_b = 1; m_av = 0; m_bv = 0; m_ad = '0; m_bd = '0;
    m_acnt = 0; m_bcnt = 0; m_ccnt = 0;
  endfunction

  function automatic longint sat(input longint v);
    return (v > (64'd1 << CW) - 1) ? (64'd1 << CW) - 1 : v;
  endfunction

  // One bus cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      output logic wa_o, output logic wb_o);
    logic wa, wb;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    if (reset) begin wa = 0; wb = 0; end
    else if (ar && br) begin wb = (m_last_b == 0); wa = !wb; end
    else begin wa = ar; wb = br; end
    check("a_gnt", a_gnt, wa);
    check("b_gnt", b_gnt, wb);
    check("ram_load", ram_load, (wa && aw) || (wb && bw));
    check("ram_address", ram_address, wb ? ba : aa);
    if (wa || wb) check("ram_in", ram_in, wb ? bd : ad);
    @(posedge clk); #1;
    if (reset) m_reset();
    else begin
      if (ar && br) m_ccnt = sat(m_ccnt + 1);
      m_av = wa && !aw;
      m_bv = wb && !bw;
      if (wa) begin
        if (aw) mdl[aa] = ad; else m_ad = mdl[aa];
        m_last_b = 0; m_acnt = sat(m_acnt + 1);
      end
      if (wb) begin
        if (bw) mdl[ba] = bd; else m_bd = mdl[ba];
        m_last_b = 1; m_bcnt = sat(m_bcnt + 1);
      end
    end
    check("a_rvalid", a_rvalid, m_av);
    check("b_rvalid", b_rvalid, m_bv);
    check("a_rdata", a_rdata, m_ad);
    check("b_rdata", b_rdata, m_bd);
`ifdef RAM16K_ARB_STATS_EN
    check("a_gnt_cnt", a_gnt_cnt, m_acnt[31:0]);
    check("b_gnt_cnt", b_gnt_cnt, m_bcnt[31:0]);
    check("conflict_cnt", conflict_cnt, m_ccnt[31:0]);
`endif
    wa_o = wa; wb_o = wb;
  endtask

  task automatic apply_reset();
    a_req = 0; b_req = 0; reset = 1; m_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 2**AW; i++) begin ram[i] = '0; mdl[i] = '0; end
    m_reset();
    @(posedge clk); #1;
    // reset held with both ports requesting writes
    step(1, 1, 14'h0010, 16'hDEAD, 1, 1, 14'h0011, 16'hBEEF, ga, gb);
    check("rst_ram", ram[14'h0010], 16'h0000);
    reset = 0;
    step(1, 0, 14'h0001, 16'h0, 1, 0, 14'h0002, 16'h0, ga, gb);
    check("first_conflict_a", ga, 1'b1);
    // A write then A read of the same word
    step(1, 1, 14'h0005, 16'h1234, 0, 0, 14'h0, 16'h0, ga, gb);
    step(1, 0, 14'h0005, 16'h0, 0, 0, 14'h0, 16'h0, ga, gb);
    check("a_read_back", a_rdata, 16'h1234);
    step(0, 0, 14'h0, 16'h0, 0, 0, 14'h0, 16'h0, ga, gb);
    // continuous contention alternates
    prev_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 14'h0005, 16'h0, 1, 0, 14'h0005, 16'h0, ga, gb);
      if (i > 0) check("alternate", gb, !prev_b);
      prev_b = gb;
    end
    // simultaneous writes to the top word, held until granted
    apply_reset();
    step(1, 1, 14'h3FFF, 16'hAAAA, 1, 1, 14'h3FFF, 16'h5555, ga, gb);
    check("w_first_a", ga, 1'b1);
    step(0, 0, 14'h0, 16'h0, 1, 1, 14'h3FFF, 16'h5555, ga, gb);
    check("ram_3fff", ram[14'h3FFF], 16'h5555);
    step(0, 0, 14'h0, 16'h0, 1, 0, 14'h3FFF, 16'h0, ga, gb);
    check("b_read_3fff", b_rdata, 16'h5555);
    // reset right after a B read grant
    step(0, 0, 14'h0, 16'h0, 1, 0, 14'h0005, 16'h0, ga, gb);
    reset = 1; m_reset();
    a_req = 1; a_we = 1; a_addr = 14'h0007; a_wdata = 16'hCAFE;
    #1;
    check("rst_b_rvalid", b_rvalid, 1'b0);
    check("rst_b_rdata", b_rdata, 16'h0000);
    check("rst_ram_load", ram_load, 1'b0);
    check("rst_a_gnt", a_gnt, 1'b0);
    @(posedge clk); #1;
    check("rst_no_write", ram[14'h0007], 16'h0000);
    reset = 0;
`ifdef RAM16K_ARB_STATS_EN
    for (int i = 0; i < 10; i++) step(1, 0, 14'h1, 16'h0, 1, 0, 14'h2, 16'h0, ga, gb);
    check("stat_a10", a_gnt_cnt, 32'd5);
    check("stat_b10", b_gnt_cnt, 32'd5);
    check("stat_c10", conflict_cnt, 32'd10);
    apply_reset();
`endif
    // randomized traffic, each requester holds until granted
    pa = 0; pb = 0; paw = 0; pbw = 0; paa = '0; pba = '0; pad = '0; pbd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; paw = 1'($urandom_range(0, 1)); paa = pick_addr(); pad = DW'($urandom);
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1; pbw = 1'($urandom_range(0, 1)); pba = pick_addr(); pbd = DW'($urandom);
      end
      step(pa, paw, paa, pad, pb, pbw, pba, pbd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    for (int i = 0; i < 8; i++) check("ram_vs_model", ram[i], mdl[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
